// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline memory-side blocks.
//   arb_state_type : sequencing state of the RAM port arbiter
//   arb_owner_type : which requester owns the access in flight
//   ENABLE / ZERO  : single-bit enable levels
//   mask_rdata     : returns read data, or zero when the access was a write
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic ENABLE = 1'b1;
    localparam logic ZERO   = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_type;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } arb_owner_type;

    // A write returns an acknowledge with all-zero data.
    function automatic logic [31:0] mask_rdata(input logic [31:0] data,
                                               input logic        is_write);
        if (is_write) begin
            mask_rdata = 32'h0000_0000;
        end else begin
            mask_rdata = data;
        end
    endfunction

endpackage

// File: rtl/ram_arb_select.sv
// -----------------------------------------------------------------------------
// ram_arb_select
// Combinational grant decision for the shared RAM port.
//   if_req      in  : fetch request
//   mem_req     in  : memory-stage request
//   starve_full in  : fetch has waited through the maximum MEM grants
//   idle        in  : arbiter can accept a new access this cycle
//   gnt         out : one-hot grant, bit 1 = MEM, bit 0 = IF
//   owner       out : owner of the access granted this cycle
// -----------------------------------------------------------------------------
module ram_arb_select
    import pipeline_pkg::*;
(
    input  logic          if_req,
    input  logic          mem_req,
    input  logic          starve_full,
    input  logic          idle,
    output logic [1:0]    gnt,
    output arb_owner_type owner
);

    // MEM has priority unless fetch has been starved long enough.
    always_comb begin
        gnt   = 2'b00;
        owner = OWN_NONE;
        if (idle) begin
            if (if_req && (starve_full || !mem_req)) begin
                gnt   = 2'b01;
                owner = OWN_IF;
            end else if (mem_req) begin
                gnt   = 2'b10;
                owner = OWN_MEM;
            end else begin
                gnt   = 2'b00;
                owner = OWN_NONE;
            end
        end else begin
            gnt   = 2'b00;
            owner = OWN_NONE;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one BRAM port between instruction fetch (IF) and the memory stage
// (MEM), one access in flight. MEM wins by default; a starvation counter lets
// fetch through after MAX_WAIT consecutive MEM grants. Read data / write
// acknowledge is returned registered, RAM_LATENCY+1 cycles after the grant.
//   clk_i, n_rst                 : clock, async active-low reset
//   if_req_i/if_addr_i           : fetch request and address
//   if_gnt_o/if_rvalid_o/if_rdata_o : fetch grant and response
//   if_flush_i                   : discard an outstanding fetch response
//   mem_req_i/we/addr/wdata      : memory-stage request
//   mem_gnt_o/rvalid/rdata       : memory-stage grant and response
//   ram_en/we/addr/wdata_o, ram_rdata_i : BRAM port
// -----------------------------------------------------------------------------
module ram_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic              clk_i,
    input  logic              n_rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              if_flush_i,
    input  logic              mem_req_i,
    input  logic [3:0]        mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_gnt_o,
    output logic              mem_rvalid_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int LAT_W = $clog2(RAM_LATENCY + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(RAM_LATENCY - 1);

    arb_state_type     state_r;
    arb_owner_type     owner_r;
    arb_owner_type     owner_sel_s;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              drop_r;
    logic              wr_pending_r;
    logic              if_rvalid_r;
    logic              mem_rvalid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic [1:0]        gnt_s;
    logic              idle_s;
    logic              gnt_if_s;
    logic              gnt_mem_s;
    logic              flush_now_s;

    // Grants are suppressed while reset is held so every output reads 0.
    assign idle_s    = (state_r == IDLE) && n_rst;
    assign gnt_if_s  = gnt_s[0];
    assign gnt_mem_s = gnt_s[1];

    // A flush during the final WAIT cycle must also cancel the response.
    assign flush_now_s = drop_r || (if_flush_i && (owner_r == OWN_IF));

    ram_arb_select u_select (
        .if_req      (if_req_i),
        .mem_req     (mem_req_i),
        .starve_full (starve_cnt_r == STARVE_MAX),
        .idle        (idle_s),
        .gnt         (gnt_s),
        .owner       (owner_sel_s)
    );

    assign if_gnt_o     = gnt_if_s;
    assign mem_gnt_o    = gnt_mem_s;
    assign if_rvalid_o  = if_rvalid_r;
    assign if_rdata_o   = if_rdata_r;
    assign mem_rvalid_o = mem_rvalid_r;
    assign mem_rdata_o  = mem_rdata_r;

    // RAM port carries the granted request only on the grant cycle, else 0.
    always_comb begin
        ram_en_o    = ZERO;
        ram_we_o    = 4'b0000;
        ram_addr_o  = {ADDR_W{1'b0}};
        ram_wdata_o = {DATA_W{1'b0}};
        if (gnt_mem_s) begin
            ram_en_o    = ENABLE;
            ram_we_o    = mem_we_i;
            ram_addr_o  = mem_addr_i;
            ram_wdata_o = mem_wdata_i;
        end else if (gnt_if_s) begin
            ram_en_o    = ENABLE;
            ram_addr_o  = if_addr_i;
        end else begin
            ram_en_o    = ZERO;
        end
    end

    // Sequencing FSM, starvation counter, flush flag and response registers.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= IDLE;
            owner_r      <= OWN_NONE;
            lat_cnt_r    <= {LAT_W{1'b0}};
            starve_cnt_r <= {CNT_W{1'b0}};
            drop_r       <= 1'b0;
            wr_pending_r <= 1'b0;
            if_rvalid_r  <= 1'b0;
            mem_rvalid_r <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            mem_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if (!if_req_i || gnt_if_s) begin
                starve_cnt_r <= {CNT_W{1'b0}};
            end else if (gnt_mem_s && (starve_cnt_r != STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end

            case (state_r)
                IDLE: begin
                    drop_r <= 1'b0;
                    if (owner_sel_s != OWN_NONE) begin
                        state_r      <= WAIT;
                        owner_r      <= owner_sel_s;
                        lat_cnt_r    <= LAT_LOAD;
                        wr_pending_r <= gnt_mem_s && (mem_we_i != 4'b0000);
                    end else begin
                        state_r      <= IDLE;
                        owner_r      <= OWN_NONE;
                    end
                end
                WAIT: begin
                    drop_r <= flush_now_s;
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        state_r <= RESP;
                        if (owner_r == OWN_IF) begin
                            if_rdata_r  <= ram_rdata_i;
                            if_rvalid_r <= !flush_now_s;
                        end else begin
                            mem_rdata_r  <= mask_rdata(ram_rdata_i, wr_pending_r);
                            mem_rvalid_r <= 1'b1;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    owner_r      <= OWN_NONE;
                    drop_r       <= 1'b0;
                    if_rvalid_r  <= 1'b0;
                    mem_rvalid_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    owner_r      <= OWN_NONE;
                    drop_r       <= 1'b0;
                    if_rvalid_r  <= 1'b0;
                    mem_rvalid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        clk_i = 1'b0;
    logic        n_rst = 1'b0;
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    // DUT with default latency
    logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0;
    logic [31:0] if_addr = 32'h0, mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [3:0]  mem_we = 4'h0;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata = 32'h0;

    // DUT with RAM_LATENCY = 3 (memory-stage only)
    logic        m3_req = 1'b0;
    logic [31:0] m3_addr = 32'h0;
    logic        i3_gnt, i3_rvalid, m3_gnt, m3_rvalid, r3_en;
    logic [31:0] i3_rdata, m3_rdata, r3_addr, r3_wdata;
    logic [3:0]  r3_we;
    logic [31:0] p3a = 32'h0, p3b = 32'h0, p3c = 32'h0;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM models: registered read, junk value when not enabled
    always @(posedge clk_i) begin
        ram_rdata <= ram_en ? ram_word(ram_addr) : 32'hBAD0_0000;
        p3a <= r3_en ? ram_word(r3_addr) : 32'hBAD0_0003;
        p3b <= p3a;
        p3c <= p3b;
    end

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(1), .MAX_WAIT(4)) dut (
        .clk_i(clk_i), .n_rst(n_rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_flush_i(if_flush),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt), .mem_rvalid_o(mem_rvalid),
        .mem_rdata_o(mem_rdata), .ram_en_o(ram_en), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(3), .MAX_WAIT(4)) dut3 (
        .clk_i(clk_i), .n_rst(n_rst),
        .if_req_i(1'b0), .if_addr_i(32'h0), .if_gnt_o(i3_gnt),
        .if_rvalid_o(i3_rvalid), .if_rdata_o(i3_rdata), .if_flush_i(1'b0),
        .mem_req_i(m3_req), .mem_we_i(4'h0), .mem_addr_i(m3_addr),
        .mem_wdata_i(32'h0), .mem_gnt_o(m3_gnt), .mem_rvalid_o(m3_rvalid),
        .mem_rdata_o(m3_rdata), .ram_en_o(r3_en), .ram_we_o(r3_we),
        .ram_addr_o(r3_addr), .ram_wdata_o(r3_wdata), .ram_rdata_i(p3c)
    );

    // Scoreboard: every response pulse must match the oldest expectation
    always @(negedge clk_i) begin
        if (n_rst) begin
            if (if_rvalid || mem_rvalid) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL resp_unexpected cyc=%0d if_rvalid=%b mem_rvalid=%b required none",
                             cyc, if_rvalid, mem_rvalid);
                end else begin
                    exp_t e;
                    logic [31:0] got;
                    e = exp_q.pop_front();
                    got = e.is_if ? if_rdata : mem_rdata;
                    if ({if_rvalid, mem_rvalid} !== {e.is_if, !e.is_if} || got !== e.data || cyc != e.due)
                        $display("FAIL resp_match cyc=%0d if/mem=%b%b data=%h required cyc=%0d if=%b data=%h",
                                 cyc, if_rvalid, mem_rvalid, got, e.due, e.is_if, e.data);
                    else
                        pass_cnt++;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                chk_cnt++;
                $display("FAIL resp_missing cyc=%0d no rvalid, required at cyc=%0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input bit is_if, input logic [31:0] data);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        e.due   = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk_cnt++;
        if ({if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata,
             m3_rvalid, m3_rdata, r3_en} !== '0)
            $display("FAIL reset_outputs got nonzero outputs (if_rdata=%h mem_rdata=%h ram_en=%b) required all 0",
                     if_rdata, mem_rdata, ram_en);
        else
            pass_cnt++;
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_mem_read();
        mem_addr = 32'h100; mem_we = 4'h0; mem_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({mem_gnt, if_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 1'b1, 4'h0, 32'h100})
            $display("FAIL read_grant gnt m/i=%b%b en=%b we=%h addr=%h required 1 0 1 0 100",
                     mem_gnt, if_gnt, ram_en, ram_we, ram_addr);
        else
            pass_cnt++;
        push(1'b0, 32'hDEAD_BEEF);
        tick();
        mem_req = 1'b0;
        @(negedge clk_i);
        chk_cnt++;
        if ({ram_en, ram_addr} !== {1'b0, 32'h0})
            $display("FAIL read_ram_idle en=%b addr=%h required 0 0", ram_en, ram_addr);
        else
            pass_cnt++;
        tick();
        mem_addr = 32'h104; mem_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if (mem_gnt !== 1'b0)
            $display("FAIL read_no_grant_in_resp mem_gnt=%b required 0", mem_gnt);
        else
            pass_cnt++;
        tick();
        @(negedge clk_i);
        chk_cnt++;
        if (mem_gnt !== 1'b1)
            $display("FAIL read_next_grant mem_gnt=%b required 1", mem_gnt);
        else
            pass_cnt++;
        push(1'b0, ram_word(32'h104));
        tick();
        mem_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_write();
        mem_addr = 32'h40; mem_we = 4'b0011; mem_wdata = 32'h1234; mem_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({mem_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h40, 32'h1234})
            $display("FAIL write_grant gnt=%b en=%b we=%b addr=%h wdata=%h required 1 1 0011 40 1234",
                     mem_gnt, ram_en, ram_we, ram_addr, ram_wdata);
        else
            pass_cnt++;
        push(1'b0, 32'h0);
        tick();
        mem_req = 1'b0; mem_we = 4'h0; mem_wdata = 32'h0;
        @(negedge clk_i);
        chk_cnt++;
        if ({ram_we, ram_wdata} !== {4'h0, 32'h0})
            $display("FAIL write_we_one_cycle we=%b wdata=%h required 0000 0", ram_we, ram_wdata);
        else
            pass_cnt++;
        repeat (3) tick();
    endtask

    task automatic test_arbitration();
        if_addr = 32'h300; mem_addr = 32'h500; if_req = 1'b1; mem_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bit exp_i, exp_m;
            exp_i = (i % 3 == 0) && (i / 3 == 4);
            exp_m = (i % 3 == 0) && (i / 3 != 4);
            @(negedge clk_i);
            chk_cnt++;
            if ({if_gnt, mem_gnt} !== {exp_i, exp_m})
                $display("FAIL arb_seq slot=%0d if/mem gnt=%b%b required %b%b",
                         i, if_gnt, mem_gnt, exp_i, exp_m);
            else
                pass_cnt++;
            if (exp_i) push(1'b1, ram_word(32'h300));
            if (exp_m) push(1'b0, ram_word(32'h500));
            tick();
        end
        if_req = 1'b0; mem_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        if_addr = 32'h200; if_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({if_gnt, ram_addr} !== {1'b1, 32'h200})
            $display("FAIL flush_grant if_gnt=%b addr=%h required 1 200", if_gnt, ram_addr);
        else
            pass_cnt++;
        tick();
        if_req = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_addr = 32'h204; if_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({if_rvalid, if_gnt} !== 2'b00)
            $display("FAIL flush_dropped if_rvalid=%b if_gnt=%b required 0 0", if_rvalid, if_gnt);
        else
            pass_cnt++;
        tick();
        @(negedge clk_i);
        chk_cnt++;
        if (if_gnt !== 1'b1)
            $display("FAIL flush_regrant if_gnt=%b required 1", if_gnt);
        else
            pass_cnt++;
        push(1'b1, ram_word(32'h204));
        tick();
        if_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_latency3();
        m3_addr = 32'h180; m3_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({m3_gnt, r3_en, r3_addr} !== {1'b1, 1'b1, 32'h180})
            $display("FAIL lat3_grant gnt=%b en=%b addr=%h required 1 1 180", m3_gnt, r3_en, r3_addr);
        else
            pass_cnt++;
        tick();
        m3_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            chk_cnt++;
            if ({r3_en, m3_rvalid} !== {1'b0, (k == 4)} || (k == 4 && m3_rdata !== ram_word(32'h180)))
                $display("FAIL lat3_resp T+%0d en=%b rvalid=%b data=%h required 0 %b %h",
                         k, r3_en, m3_rvalid, m3_rdata, (k == 4), ram_word(32'h180));
            else
                pass_cnt++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        mem_addr = 32'h100; mem_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if (mem_gnt !== 1'b1)
            $display("FAIL rstmid_grant mem_gnt=%b required 1", mem_gnt);
        else
            pass_cnt++;
        tick();
        mem_req = 1'b0; n_rst = 1'b0;
        @(negedge clk_i);
        chk_cnt++;
        if ({if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata} !== '0)
            $display("FAIL rstmid_outputs mem_rdata=%h if_rdata=%h rvalid=%b%b required all 0",
                     mem_rdata, if_rdata, if_rvalid, mem_rvalid);
        else
            pass_cnt++;
        tick();
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk_cnt++;
            if ({if_rvalid, mem_rvalid} !== 2'b00)
                $display("FAIL rstmid_no_rvalid k=%0d rvalid=%b%b required 00", k, if_rvalid, mem_rvalid);
            else
                pass_cnt++;
            tick();
        end
        mem_addr = 32'h108; mem_req = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if (mem_gnt !== 1'b1)
            $display("FAIL rstmid_regrant mem_gnt=%b required 1", mem_gnt);
        else
            pass_cnt++;
        push(1'b0, ram_word(32'h108));
        tick();
        mem_req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mem_read();
        test_write();
        test_arbitration();
        test_flush();
        test_latency3();
        test_reset_mid();
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL drain %0d responses outstanding, required 0", exp_q.size());
        else
            pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
